// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family: width limit and
// width-generic binary/Gray conversion helpers. Functions operate on
// GRAY_MAX_WIDTH bits; narrower callers zero-extend and truncate.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Binary to reflected Gray: each bit is the XOR of itself and its upper
  // neighbour, so consecutive binary values differ in exactly one Gray bit.
  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at and
  // above its position (prefix XOR from the MSB down).
  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix chain). Used alongside
// the counter to recover the binary count from its Gray output.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of the Gray bits from its position upward.
  always_comb begin
    // NOTE: every bit gets a value on every pass through always_comb, so no latch is inferred.
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter with up/down counting, synchronous clear,
// parallel load, a sticky Overflow flag and a one-cycle Wrap pulse.
// Build option: define GRAY_CNT_SATURATE_EN to make the count saturate at
// its end points instead of wrapping modulo 2^WIDTH. Ports are the same in
// both builds.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 3  // legal range 2..GRAY_MAX_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] BIN_MAX = '1;
  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;
  logic             at_limit;
  logic             wrap_event;

  // Next-state selection with priority Clear > Load > En > hold; a wrap is
  // only recognised when the counting branch is actually the one taken.
  always_comb begin
    at_limit   = Dir ? (bin == BIN_MAX) : (bin == '0);
    wrap_event = En && !Clear && !Load && at_limit;
    bin_next   = bin;
    if (Clear) begin
      bin_next = '0;
    end else if (Load) begin
      bin_next = LoadVal;
    end else if (En) begin
`ifdef GRAY_CNT_SATURATE_EN
      // End points are sticky: a blocked step leaves the count in place.
      if (!at_limit) begin
        bin_next = Dir ? (bin + BIN_ONE) : (bin - BIN_ONE);
      end
`else
      // WIDTH-bit arithmetic: carry/borrow out falls off, giving modulo wrap.
      bin_next = Dir ? (bin + BIN_ONE) : (bin - BIN_ONE);
`endif
    end
  end

  // State, Gray output and flags all update on the same edge, so the Gray
  // output is a register and never a combinational function of the inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bin      <= '0;
      Output   <= '0;
      Overflow <= 1'b0;
      Wrap     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bin      <= bin_next;
      Output   <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
      Wrap     <= wrap_event;
      if (Clear) begin
        Overflow <= 1'b0;
      end else if (wrap_event) begin
        Overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: directed table at WIDTH=3, load/clear sequence
// at WIDTH=4, asynchronous reset corner at WIDTH=3, and a randomised
// invariant run at WIDTH=5. Expectations follow GRAY_CNT_SATURATE_EN when set.
module tb_gray_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- WIDTH=3 instance ----------------
  logic       rst3, en3, dir3, clr3, ld3, ovf3, wrap3;
  logic [2:0] lv3, out3;

  gray_counter_n #(.WIDTH(3)) dut3 (
    .Clk(clk), .Reset(rst3), .En(en3), .Dir(dir3), .Clear(clr3), .Load(ld3),
    .LoadVal(lv3), .Output(out3), .Overflow(ovf3), .Wrap(wrap3)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic       rst4, en4, dir4, clr4, ld4, ovf4, wrap4;
  logic [3:0] lv4, out4;

  gray_counter_n #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(rst4), .En(en4), .Dir(dir4), .Clear(clr4), .Load(ld4),
    .LoadVal(lv4), .Output(out4), .Overflow(ovf4), .Wrap(wrap4)
  );

  // ---------------- WIDTH=5 instance ----------------
  logic       rst5, en5, dir5, clr5, ld5, ovf5, wrap5;
  logic [4:0] lv5, out5, bin5;

  gray_counter_n #(.WIDTH(5)) dut5 (
    .Clk(clk), .Reset(rst5), .En(en5), .Dir(dir5), .Clear(clr5), .Load(ld5),
    .LoadVal(lv5), .Output(out5), .Overflow(ovf5), .Wrap(wrap5)
  );

  gray2bin_conv #(.WIDTH(5)) conv5 (.gray(out5), .bin(bin5));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       en;
    logic       dir;
    logic       clr;
    logic       ld;
    logic [2:0] lv;
    logic [2:0] out;
    logic       ovf;
    logic       wrap;
  } vec_t;

  function automatic vec_t v(input logic en, input logic dir, input logic clr,
                             input logic ld, input logic [2:0] lv,
                             input logic [2:0] out, input logic ovf,
                             input logic wrap);
    vec_t r;
    r.en = en; r.dir = dir; r.clr = clr; r.ld = ld; r.lv = lv;
    r.out = out; r.ovf = ovf; r.wrap = wrap;
    return r;
  endfunction

  vec_t tbl[$];

  // WIDTH=5 reference model
  logic [4:0] mb;
  logic       movf, mwrap, mat, mwe, stepped;
  logic [4:0] prev_out, mgray, diff;

  initial begin
    rst3 = 1'b1; en3 = 0; dir3 = 0; clr3 = 0; ld3 = 0; lv3 = '0;
    rst4 = 1'b1; en4 = 0; dir4 = 0; clr4 = 0; ld4 = 0; lv4 = '0;
    rst5 = 1'b1; en5 = 0; dir5 = 0; clr5 = 0; ld5 = 0; lv5 = '0;

    // ---- directed table for WIDTH=3 ----
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b001, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b011, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b010, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b110, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b111, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b101, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b100, 0, 0));
`ifdef GRAY_CNT_SATURATE_EN
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b100, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b100, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b100, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 3'd0, 3'b100, 1, 0));
`else
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b000, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b001, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b011, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 3'd0, 3'b011, 1, 0));
`endif
    tbl.push_back(v(0, 1, 1, 0, 3'd0, 3'b000, 0, 0));
`ifdef GRAY_CNT_SATURATE_EN
    tbl.push_back(v(1, 0, 0, 0, 3'd0, 3'b000, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b001, 1, 0));
`else
    tbl.push_back(v(1, 0, 0, 0, 3'd0, 3'b100, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b000, 1, 1));
`endif
    tbl.push_back(v(0, 1, 1, 0, 3'd0, 3'b000, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 3'd0, 3'b000, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 3'd5, 3'b111, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 3'd0, 3'b110, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 3'd6, 3'b000, 0, 0));
`ifdef GRAY_CNT_SATURATE_EN
    tbl.push_back(v(1, 0, 0, 0, 3'd0, 3'b000, 1, 1));
`else
    tbl.push_back(v(1, 0, 0, 0, 3'd0, 3'b100, 1, 1));
`endif
    tbl.push_back(v(0, 0, 0, 1, 3'd3, 3'b010, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b110, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 3'd0, 3'b010, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 3'd0, 3'b110, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 3'd0, 3'b110, 1, 0));

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_out3", 32'(out3), 32'd0);
    check("rst_ovf3", 32'(ovf3), 32'd0);
    check("rst_wrap3", 32'(wrap3), 32'd0);
    check("rst_out5", 32'(out5), 32'd0);
    rst3 = 1'b0; rst4 = 1'b0; rst5 = 1'b0;

    foreach (tbl[i]) begin
      en3 = tbl[i].en; dir3 = tbl[i].dir; clr3 = tbl[i].clr;
      ld3 = tbl[i].ld; lv3 = tbl[i].lv;
      @(posedge clk);
      #1;
      check($sformatf("t%0d_out", i), 32'(out3), 32'(tbl[i].out));
      check($sformatf("t%0d_ovf", i), 32'(ovf3), 32'(tbl[i].ovf));
      check($sformatf("t%0d_wrap", i), 32'(wrap3), 32'(tbl[i].wrap));
    end

    // ---- asynchronous reset between edges with Overflow set ----
    en3 = 1'b1; dir3 = 1'b1;
    #2;
    rst3 = 1'b1;
    #1;
    check("arst_out", 32'(out3), 32'd0);
    check("arst_ovf", 32'(ovf3), 32'd0);
    check("arst_wrap", 32'(wrap3), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_out", 32'(out3), 32'd0);
    rst3 = 1'b0; en3 = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out3), 32'd0);
    en3 = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_first", 32'(out3), 32'b001);
    en3 = 1'b0;

    // ---- WIDTH=4: set overflow, load 9, clear ----
    en4 = 1'b1; dir4 = 1'b0;
    @(posedge clk);
    #1;
`ifdef GRAY_CNT_SATURATE_EN
    check("w4_down_out", 32'(out4), 32'b0000);
`else
    check("w4_down_out", 32'(out4), 32'b1000);
`endif
    check("w4_down_wrap", 32'(wrap4), 32'd1);
    ld4 = 1'b1; lv4 = 4'd9;
    @(posedge clk);
    #1;
    check("w4_load_out", 32'(out4), 32'b1101);
    check("w4_load_ovf", 32'(ovf4), 32'd1);
    check("w4_load_wrap", 32'(wrap4), 32'd0);
    ld4 = 1'b0; clr4 = 1'b1;
    @(posedge clk);
    #1;
    check("w4_clr_out", 32'(out4), 32'b0000);
    check("w4_clr_ovf", 32'(ovf4), 32'd0);
    clr4 = 1'b0; ld4 = 1'b1; lv4 = 4'd15; en4 = 1'b0;
    @(posedge clk);
    #1;
    check("w4_max_out", 32'(out4), 32'b1000);
    ld4 = 1'b0; en4 = 1'b1; dir4 = 1'b1;
    @(posedge clk);
    #1;
`ifdef GRAY_CNT_SATURATE_EN
    check("w4_up_out", 32'(out4), 32'b1000);
`else
    check("w4_up_out", 32'(out4), 32'b0000);
`endif
    check("w4_up_wrap", 32'(wrap4), 32'd1);
    check("w4_up_ovf", 32'(ovf4), 32'd1);
    en4 = 1'b0;

    // ---- WIDTH=5 randomised invariants ----
    mb = '0; movf = 1'b0; mwrap = 1'b0;
    prev_out = out5;
    for (int c = 0; c < 1000; c++) begin
      en5  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir5 = ~dir5;
      ld5  = ($urandom_range(0, 19) == 0);
      clr5 = ($urandom_range(0, 49) == 0);
      lv5  = 5'($urandom_range(0, 31));

      mat = dir5 ? (mb == 5'd31) : (mb == 5'd0);
      mwe = en5 && !clr5 && !ld5 && mat;
      stepped = 1'b0;
      if (clr5) begin
        mb = '0;
      end else if (ld5) begin
        mb = lv5;
      end else if (en5) begin
`ifdef GRAY_CNT_SATURATE_EN
        if (!mat) begin
          mb = dir5 ? mb + 5'd1 : mb - 5'd1;
          stepped = 1'b1;
        end
`else
        mb = dir5 ? mb + 5'd1 : mb - 5'd1;
        stepped = 1'b1;
`endif
      end
      mwrap = mwe;
      movf  = clr5 ? 1'b0 : (movf | mwe);
      mgray = mb ^ (mb >> 1);

      @(posedge clk);
      #1;
      check($sformatf("r%0d_bin", c), 32'(bin5), 32'(mb));
      check($sformatf("r%0d_gray", c), 32'(out5), 32'(mgray));
      check($sformatf("r%0d_ovf", c), 32'(ovf5), 32'(movf));
      check($sformatf("r%0d_wrap", c), 32'(wrap5), 32'(mwrap));
      if (stepped) begin
        diff = out5 ^ prev_out;
        check($sformatf("r%0d_onebit", c), 32'($countones(diff)), 32'd1);
      end
      prev_out = out5;
    end
    en5 = 1'b0; ld5 = 1'b0; clr5 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
